// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch-side instruction cache.
// No logic; constants, address-field helpers and the fill FSM state type.
// Field widths are derived from the cache geometry parameters of the user.
package fetch_pkg;

  localparam int INSTR_W    = 32;
  localparam int ADDR_W     = 32;
  localparam int BYTE_OFF_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } fill_state_t;

  // Bits selecting a word within a line.
  function automatic int word_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  // Bits selecting a line.
  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  // Remaining upper address bits form the tag.
  function automatic int tag_w(input int lines, input int words_per_line);
    return ADDR_W - BYTE_OFF_W - $clog2(words_per_line) - $clog2(lines);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Tag, valid and data storage for the direct-mapped instruction cache.
// Reads are combinational; word, tag and invalidate writes land at the next posedge.
// No backpressure: every write request is accepted in the cycle it is presented.
module icache_array
  import fetch_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int IDX_W          = $clog2(LINES),
  parameter int WORD_W         = $clog2(WORDS_PER_LINE),
  parameter int TAG_W          = ADDR_W - BYTE_OFF_W - WORD_W - IDX_W
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [IDX_W-1:0]   RdIdx,
  input  logic [WORD_W-1:0]  RdWord,
  output logic               RdValid,
  output logic [TAG_W-1:0]   RdTag,
  output logic [INSTR_W-1:0] RdData,
  input  logic               WordWe,
  input  logic [IDX_W-1:0]   WrIdx,
  input  logic [WORD_W-1:0]  WrWord,
  input  logic [INSTR_W-1:0] WrData,
  input  logic               TagWe,
  input  logic [IDX_W-1:0]   TagIdx,
  input  logic [TAG_W-1:0]   TagData,
  input  logic               InvalAll
);

  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tags [LINES];
  logic [INSTR_W-1:0] words [LINES][WORDS_PER_LINE];

  // Asynchronous read port feeding the same-cycle hit path.
  always_comb begin
    RdValid = valid[RdIdx];
    RdTag   = tags[RdIdx];
    RdData  = words[RdIdx][RdWord];
  end

  // Valid bits: invalidate-all wins over an install in the same cycle.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      valid <= '0;
    end else if (InvalAll) begin
      valid <= '0;
    end else if (TagWe) begin
      valid[TagIdx] <= 1'b1;
    end
  end

  // Tag storage is written only on install and is never reset.
  always_ff @(posedge Clk) begin
    if (TagWe) begin
      tags[TagIdx] <= TagData;
    end
  end

  // Data storage takes one fill beat per write and is never reset.
  always_ff @(posedge Clk) begin
    if (WordWe) begin
      words[WrIdx][WrWord] <= WrData;
    end
  end

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache answering fetch requests; fills lines from backing memory.
// Hits return Data in the same cycle; a miss costs detect + REQ + WORDS_PER_LINE beats + DONE.
// Imiss stalls fetch during miss/fill; MemReq holds until MemGnt, and fill beats may have gaps.
module icache_responder
  import fetch_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int MISS_CNT_W     = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  En,
  input  logic [ADDR_W-1:0]     Addr,
  output logic [INSTR_W-1:0]    Data,
  output logic                  Imiss,
  input  logic                  Inval,
  output logic                  MemReq,
  output logic [ADDR_W-1:0]     MemAddr,
  input  logic                  MemGnt,
  input  logic                  MemValid,
  input  logic [INSTR_W-1:0]    MemData,
  output logic [MISS_CNT_W-1:0] MissCount
);

  localparam int WORD_W  = word_w(WORDS_PER_LINE);
  localparam int IDX_W   = idx_w(LINES);
  localparam int TAG_W   = tag_w(LINES, WORDS_PER_LINE);
  localparam int WORD_LO = BYTE_OFF_W;
  localparam int IDX_LO  = WORD_LO + WORD_W;
  localparam int TAG_LO  = IDX_LO + IDX_W;
  localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(WORDS_PER_LINE - 1);

  fill_state_t        state;
  logic [WORD_W-1:0]  beat;
  logic               abort;

  logic [WORD_W-1:0]  addr_word;
  logic [IDX_W-1:0]   addr_idx;
  logic [TAG_W-1:0]   addr_tag;
  logic [IDX_W-1:0]   fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic               hit;
  logic               miss_req;
  logic               word_we;
  logic               tag_we;

  // Address split for the lookup and for the latched fill line.
  always_comb begin
    addr_word = Addr[IDX_LO-1:WORD_LO];
    addr_idx  = Addr[TAG_LO-1:IDX_LO];
    addr_tag  = Addr[ADDR_W-1:TAG_LO];
    fill_idx  = MemAddr[TAG_LO-1:IDX_LO];
    fill_tag  = MemAddr[ADDR_W-1:TAG_LO];
  end

  // Hit/miss and array write strobes; Imiss is combinational so a missed word is never captured.
  always_comb begin
    hit      = rd_valid && (rd_tag == addr_tag);
    miss_req = En && !hit;
    Imiss    = (state != IDLE) || miss_req;
    word_we  = (state == FILL) && MemValid;
    // An invalidate that lands in DONE also suppresses the install.
    tag_we   = (state == DONE) && !abort && !Inval;
  end

  icache_array #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .IDX_W          (IDX_W),
    .WORD_W         (WORD_W),
    .TAG_W          (TAG_W)
  ) u_array (
    .Clk      (Clk),
    .Rst      (Rst),
    .RdIdx    (addr_idx),
    .RdWord   (addr_word),
    .RdValid  (rd_valid),
    .RdTag    (rd_tag),
    .RdData   (Data),
    .WordWe   (word_we),
    .WrIdx    (fill_idx),
    .WrWord   (beat),
    .WrData   (MemData),
    .TagWe    (tag_we),
    .TagIdx   (fill_idx),
    .TagData  (fill_tag),
    .InvalAll (Inval)
  );

  // Fill FSM with registered request, line address, beat counter, abort flag and miss counter.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state     <= IDLE;
      MemReq    <= 1'b0;
      MemAddr   <= '0;
      beat      <= '0;
      abort     <= 1'b0;
      MissCount <= '0;
    end else begin
      case (state)
        IDLE: begin
          // An Inval seen here has already cleared valid, so the new line may install.
          if (miss_req) begin
            MemAddr <= {Addr[ADDR_W-1:IDX_LO], {IDX_LO{1'b0}}};
            MemReq  <= 1'b1;
            beat    <= '0;
            state   <= REQ;
            if (MissCount != {MISS_CNT_W{1'b1}}) begin
              MissCount <= MissCount + MISS_CNT_W'(1);
            end
          end
        end
        REQ: begin
          if (Inval) begin
            abort <= 1'b1;
          end
          if (MemGnt) begin
            MemReq <= 1'b0;
            state  <= FILL;
          end
        end
        FILL: begin
          if (Inval) begin
            abort <= 1'b1;
          end
          if (MemValid) begin
            // Wraps back to zero after the last beat, ready for the next fill.
            beat <= beat + WORD_W'(1);
            if (beat == LAST_BEAT) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          abort <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Instruction-memory responder serving the fetch stage's request port: En, Addr, Data, Imiss.
- Direct-mapped instruction cache. Hits return the instruction word combinationally in the same cycle.
- On a miss it holds Imiss high and fetches the whole line from backing memory over a request/grant + beat-valid handshake, then installs the line.
- Replaces the flat ROM behind the fetch stage; Imiss drives the fetch-side stall.

Parameters:
- LINES, 16, number of cache lines (power of 2, at least 2).
- WORDS_PER_LINE, 4, 32-bit words per line (power of 2, at least 2).
- MISS_CNT_W, 16, width of the saturating miss counter.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Rst  in  1  synchronous, active-low reset (Rst==0 at posedge resets).
- En  in  1  fetch request valid. Low means the fetch stage is flushed or stalled.
- Addr  in  32  fetch byte address. Bits [1:0] are ignored.
- Data  out  32  instruction word for Addr. Valid when En=1 and Imiss=0.
- Imiss  out  1  miss or fill in progress; fetch must hold.
- Inval  in  1  invalidate all lines (e.g. after a code write).
- MemReq  out  1  line-fill request to backing memory.
- MemAddr  out  32  line-aligned byte address of the fill.
- MemGnt  in  1  backing memory accepts the request.
- MemValid  in  1  a fill beat is present on MemData.
- MemData  in  32  fill beat. Beats arrive in ascending word order.
- MissCount  out  MISS_CNT_W  count of misses since reset; saturates.

Behaviour:
- Address split: offset [1:0]; word = next log2(WORDS_PER_LINE) bits; index = next log2(LINES) bits; tag = remaining upper bits.
- Hit = valid[index] and (tag_array[index] == tag). Arrays are read asynchronously.
- Data = data_array[index][word]. Data is don't-care on a miss; the bench checks it only when En=1 and Imiss=0.
- Imiss = (state != IDLE) or (En and not hit). It is combinational, so the fetch register never captures a missed word.
- FSM states:
  - IDLE: if En and not hit, latch the line address {Addr[31:idx_lo_of_word], zeros} into MemAddr and go to REQ. If En is low, never miss.
  - REQ: MemReq=1. On MemGnt=1, go to FILL at the next edge. MemReq drops in that same next cycle.
  - FILL: each cycle with MemValid=1 writes MemData to data_array[latched index][beat], then beat++. After beat WORDS_PER_LINE-1, go to DONE. MemValid gaps are allowed.
  - DONE: write tag_array and set valid, unless an abort is pending. Go to IDLE. Imiss stays high in DONE; the hit is visible the cycle after.
- Minimum miss penalty: 1 (detect) + 1 (REQ, if MemGnt is immediate) + WORDS_PER_LINE beats + 1 (DONE) cycles before Imiss falls.
- Changes to Addr or En during REQ/FILL/DONE are ignored; the latched line completes. If the new Addr then misses, a fresh fill starts from IDLE.
- Inval:
  - Clears all valid bits at the posedge.
  - If Inval arrives while in REQ or FILL, set an abort flag. The fill runs to completion, but DONE does not set valid. The flag clears in DONE.
  - Inval in DONE also suppresses the install.
- MissCount increments on each IDLE→REQ transition and saturates at all-ones.
- Reset values: state IDLE, all valid bits 0, beat counter 0, abort flag 0, MemReq 0, MemAddr 0, MissCount 0.
  - Imiss is 0 after reset until En with a miss arrives.
  - Data arrays are not reset.
- Reset mid-fill drops MemReq at once and discards partial data. The backing memory must tolerate an abandoned burst.
- Simultaneous events: if En-miss and Inval occur in IDLE in the same cycle, the fill still starts, and the install proceeds because Inval preceded REQ.

Decomposition:
- Shared package fetch_pkg:
  - INSTR_W = 32.
  - Address field widths/offsets derived from LINES and WORDS_PER_LINE.
  - FSM state enum {IDLE, REQ, FILL, DONE}.
- One sub-module, icache_array:
  - Tag, valid and data storage.
  - Async read port.
  - One synchronous word-write port, one tag-write port, invalidate-all.
- The FSM, counters and handshake stay in icache_responder.

Test Plan:
- Cold miss: after reset, En=1, Addr=0x00000008; memory grants next cycle and returns 0x11,0x22,0x33,0x44. Expect MemReq high for 1 cycle, MemAddr=0x0, Imiss high for 7 cycles, then Data=0x33 with Imiss=0 and MissCount=1.
- Hit sweep: after that fill, Addr 0x0/0x4/0xC on consecutive cycles. Expect Data 0x11/0x22/0x44, Imiss=0 throughout, no MemReq.
- Conflict eviction: Addr=0x100 (same index, LINES=16, 4 words). Expect MemAddr=0x100 and refill. Afterwards Addr=0x0 misses again and MissCount=3.
- Gapped beats with slow grant: MemGnt after 3 cycles, MemValid pattern 1,0,0,1,1,0,1. Expect all 4 words installed in order, and Imiss falls one cycle after DONE.
- Inval mid-fill: assert Inval in the 2nd FILL cycle. Expect the fill to complete, the line to stay invalid, and the same Addr to miss again (MissCount+1).
- Reset mid-fill: Rst=0 during FILL. Expect next cycle state IDLE, MemReq=0, Imiss=0 with En=0, MissCount=0, and a previously valid address to miss.
